// File: rtl/ebpf_alu32_issue.sv
// ebpf_alu32_issue: sequences one eBPF ALU32 instruction through the register
//    file read port, the external combinational ALU and register file writeback.
// Latency: accept edge to done is 4 cycles for X-form binary ops,
//    3 for K-form ops, NEG and MOV X, and 2 for MOV K.
// Backpressure: insn_ready is high only in IDLE. insn_valid is ignored while an
//    instruction is in flight.
//
// Ports:
//    clk, rst_n                    core clock, synchronous active-low reset
//    insn_valid/insn_ready         instruction handshake
//    insn_opcode/dst/src/imm       decoded instruction fields
//    rf_re/rf_raddr/rf_rdata       register file read port (data one cycle after rf_re)
//    alu_op/alu_a/alu_b/alu_result combinational ALU interface
//    rf_we/rf_waddr/rf_wdata       register file write port
//    done/illegal                  one-cycle completion / rejection pulses
//
// Optional build macro: EBPF_DIV0_GUARD_EN. When it is defined, DIV by zero
// writes 0 and MOD by zero writes the original dst value, regardless of what
// the ALU returns.

module ebpf_alu32_issue #(
   parameter int NREGS = 11,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,

   input  logic          insn_valid,
   output logic          insn_ready,
   input  logic [7:0]    insn_opcode,
   input  logic [3:0]    insn_dst,
   input  logic [3:0]    insn_src,
   input  logic [DW-1:0] insn_imm,

   output logic          rf_re,
   output logic [3:0]    rf_raddr,
   input  logic [DW-1:0] rf_rdata,

   output logic [3:0]    alu_op,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   input  logic [DW-1:0] alu_result,

   output logic          rf_we,
   output logic [3:0]    rf_waddr,
   output logic [DW-1:0] rf_wdata,

   output logic          done,
   output logic          illegal
);

   // ------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RD_DST = 3'd1;
   localparam logic [2:0] S_RD_SRC = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;

   localparam logic [2:0] CLASS_ALU32 = 3'b100;

   localparam logic [3:0] OP_DIV  = 4'h3;
   localparam logic [3:0] OP_NEG  = 4'h8;
   localparam logic [3:0] OP_MOD  = 4'h9;
   localparam logic [3:0] OP_MOV  = 4'hB;
   localparam logic [3:0] OP_ARSH = 4'hC;

   // The top register is the read-only frame pointer: it may be a source
   // but never a destination.
   localparam logic [3:0] MAX_SRC = 4'(NREGS - 1);
   localparam logic [3:0] MAX_DST = 4'(NREGS - 2);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic          ready_q;
   logic          illegal_q;

   // Latched instruction fields
   logic [3:0]    op_q;
   logic          src_x_q;
   logic [3:0]    dst_q;
   logic [3:0]    src_q;
   logic [DW-1:0] imm_q;

   // Operand A capture and the "previous state was RD_DST" marker. The marker
   // tells us where the dst value is this cycle: on rf_rdata directly (just
   // read) or already parked in a_q (a src read followed it).
   logic          from_rd_dst;
   logic [DW-1:0] a_q;

   // ALU operand hold registers and writeback data
   logic [DW-1:0] alu_a_q;
   logic [DW-1:0] alu_b_q;
   logic [DW-1:0] wdata_q;

   // ------------------------------------------------------------------
   // Incoming instruction decode and legality
   // ------------------------------------------------------------------
   logic [3:0] in_op;
   logic       in_x;
   logic [2:0] in_cls;
   logic       in_legal;
   logic       accept;

   assign in_op  = insn_opcode[7:4];
   assign in_x   = insn_opcode[3];
   assign in_cls = insn_opcode[2:0];

   assign in_legal = (in_cls == CLASS_ALU32)
                  && ((in_op <= OP_MOV) || (in_op == OP_ARSH))
                  && (insn_dst <= MAX_DST)
                  && (!in_x || (insn_src <= MAX_SRC));

   // ready_q is only ever set while the next state is IDLE, so it doubles
   // as the "in IDLE" qualifier for the handshake.
   assign accept = insn_valid && ready_q;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept && in_legal) begin
               // MOV ignores the old dst value, so its dst read is skipped.
               if (in_op == OP_MOV) begin
                  state_nxt = in_x ? S_RD_SRC : S_EXEC;
               end else begin
                  state_nxt = S_RD_DST;
               end
            end
         end
         S_RD_DST: begin
            // NEG is unary: its dst read is the only read.
            state_nxt = (src_x_q && (op_q != OP_NEG)) ? S_RD_SRC : S_EXEC;
         end
         S_RD_SRC: state_nxt = S_EXEC;
         S_EXEC:   state_nxt = S_WB;
         S_WB:     state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Execute-stage operands and writeback value
   // ------------------------------------------------------------------
   logic [DW-1:0] exec_a;
   logic [DW-1:0] exec_b;
   logic [DW-1:0] wb_val;
   logic          in_exec;

   assign in_exec = (state == S_EXEC);

   // If EXEC follows RD_DST directly, the dst value is on rf_rdata right now.
   // Otherwise it was parked in a_q during RD_SRC (or is a don't-care for MOV).
   assign exec_a = from_rd_dst ? rf_rdata : a_q;
   // For the X-form the most recent read (src, or dst for NEG) is on rf_rdata.
   assign exec_b = src_x_q ? rf_rdata : imm_q;

`ifdef EBPF_DIV0_GUARD_EN
   always_comb begin
      wb_val = alu_result;
      if (exec_b == '0) begin
         if (op_q == OP_DIV) begin
            wb_val = '0;
         end else if (op_q == OP_MOD) begin
            wb_val = exec_a;
         end
      end
   end
`else
   assign wb_val = alu_result;
`endif

   // ------------------------------------------------------------------
   // Sequential state
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         ready_q     <= 1'b0;
         illegal_q   <= 1'b0;
         op_q        <= '0;
         src_x_q     <= 1'b0;
         dst_q       <= '0;
         src_q       <= '0;
         imm_q       <= '0;
         from_rd_dst <= 1'b0;
         a_q         <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         wdata_q     <= '0;
      end else begin
         state       <= state_nxt;
         // Registered so that ready rises one cycle after reset release and
         // drops in the same cycle the FSM leaves IDLE.
         ready_q     <= (state_nxt == S_IDLE);
         illegal_q   <= accept && !in_legal;
         from_rd_dst <= (state == S_RD_DST);

         if (accept) begin
            op_q    <= in_op;
            src_x_q <= in_x;
            dst_q   <= insn_dst;
            src_q   <= insn_src;
            imm_q   <= insn_imm;
         end

         // rf_rdata during RD_SRC carries the dst value read in RD_DST.
         if ((state == S_RD_SRC) && from_rd_dst) begin
            a_q <= rf_rdata;
         end

         if (in_exec) begin
            alu_a_q <= exec_a;
            alu_b_q <= exec_b;
            wdata_q <= wb_val;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign insn_ready = ready_q;

   assign rf_re    = (state == S_RD_DST) || (state == S_RD_SRC);
   assign rf_raddr = (state == S_RD_SRC) ? src_q : dst_q;

   assign alu_op = op_q;
   // Outside EXEC the ALU operands hold the values last used.
   assign alu_a  = in_exec ? exec_a : alu_a_q;
   assign alu_b  = in_exec ? exec_b : alu_b_q;

   assign rf_we    = (state == S_WB);
   assign rf_waddr = dst_q;
   assign rf_wdata = wdata_q;

   assign done    = (state == S_WB);
   assign illegal = illegal_q;

endmodule

// File: tb/tb_ebpf_alu32_issue.sv
// tb_ebpf_alu32_issue: table-driven directed vectors, a mid-instruction reset
//    sequence and randomized instructions checked against an architectural
//    register-file model that computes dst := op(dst, src|imm) directly.

module tb_ebpf_alu32_issue;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          insn_valid;
   logic          insn_ready;
   logic [7:0]    insn_opcode;
   logic [3:0]    insn_dst;
   logic [3:0]    insn_src;
   logic [DW-1:0] insn_imm;
   logic          rf_re;
   logic [3:0]    rf_raddr;
   logic [DW-1:0] rf_rdata;
   logic [3:0]    alu_op;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [DW-1:0] alu_result;
   logic          rf_we;
   logic [3:0]    rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          done;
   logic          illegal;

   always #5 clk = ~clk;

   ebpf_alu32_issue #(.NREGS(11), .DW(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .insn_valid  (insn_valid),
      .insn_ready  (insn_ready),
      .insn_opcode (insn_opcode),
      .insn_dst    (insn_dst),
      .insn_src    (insn_src),
      .insn_imm    (insn_imm),
      .rf_re       (rf_re),
      .rf_raddr    (rf_raddr),
      .rf_rdata    (rf_rdata),
      .alu_op      (alu_op),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_result  (alu_result),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .done        (done),
      .illegal     (illegal)
   );

   // ---------------- bench ALU (eBPF ALU32 semantics) ----------------
   // Division by zero returns recognisable junk so an unguarded build can be
   // told apart from a guarded one.
   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'h0: return a + b;
         4'h1: return a - b;
         4'h2: return a * b;
         4'h3: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         4'h4: return a | b;
         4'h5: return a & b;
         4'h6: return a << b[4:0];
         4'h7: return a >> b[4:0];
         4'h8: return 32'd0 - a;
         4'h9: return (b == 0) ? 32'hA5A5_A5A5 : a % b;
         4'hA: return a ^ b;
         4'hB: return b;
         4'hC: return 32'($signed(a) >>> b[4:0]);
         default: return 32'd0;
      endcase
   endfunction

   always_comb alu_result = alu_fn(alu_op, alu_a, alu_b);

   // ---------------- bench register file ----------------
   logic [31:0] rf_mem [0:15];
   logic        pre_we;
   logic [3:0]  pre_addr;
   logic [31:0] pre_data;

   always @(posedge clk) begin
      if (rf_we)       rf_mem[rf_waddr] <= rf_wdata;
      else if (pre_we) rf_mem[pre_addr] <= pre_data;
      if (rf_re)       rf_rdata <= rf_mem[rf_raddr];
   end

   // ---------------- reference model ----------------
   logic [31:0] ref_regs [0:15];
   int total = 0;
   int bad   = 0;

   function automatic logic model_legal(input logic [7:0] opc, input logic [3:0] d, input logic [3:0] s);
      return (opc[2:0] == 3'b100) && ((opc[7:4] <= 4'hB) || (opc[7:4] == 4'hC))
          && (d <= 4'd9) && (!opc[3] || (s <= 4'd10));
   endfunction

   function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] d, input logic [31:0] b);
`ifdef EBPF_DIV0_GUARD_EN
      if (op == 4'h3 && b == 0) return 32'd0;
      if (op == 4'h9 && b == 0) return d;
`endif
      return alu_fn(op, d, b);
   endfunction

   // Cycles from accept to done: each register read, then EXEC, then WB.
   function automatic int model_lat(input logic [7:0] opc);
      if (opc[7:4] == 4'hB) return opc[3] ? 3 : 2;
      if (opc[3] && opc[7:4] != 4'h8) return 4;
      return 3;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge.
   task automatic set_reg(input logic [3:0] a, input logic [31:0] v);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = v;
      ref_regs[a] = v;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // Issue one instruction and observe six cycles after the accept edge.
   task automatic run_insn(input string nm, input logic [7:0] opc, input logic [3:0] d,
                           input logic [3:0] s, input logic [31:0] imm,
                           input logic exp_legal, input logic [31:0] exp_wdata, input int lat);
      int nrd, nwe, ndone, nill, done_cyc, ill_cyc, rdy_bad, overlap, exp_nrd, waited;
      logic [3:0]  rda [0:7];
      logic [3:0]  erda [0:1];
      logic [3:0]  wa, exop;
      logic [31:0] wd, ea, eb, ha, hb;
      nrd = 0; nwe = 0; ndone = 0; nill = 0; done_cyc = 0; ill_cyc = 0;
      rdy_bad = 0; overlap = 0; wa = 0; wd = 0; exop = 0; ea = 0; eb = 0; ha = 0; hb = 0;
      for (int i = 0; i < 8; i++) rda[i] = 4'd0;
      // expected read sequence
      erda[0] = d; erda[1] = s;
      if (opc[7:4] == 4'hB) begin
         exp_nrd = opc[3] ? 1 : 0;
         erda[0] = s;
      end else if (opc[3] && opc[7:4] != 4'h8) exp_nrd = 2;
      else exp_nrd = 1;

      waited = 0;
      while (!insn_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!insn_ready) begin
         check({nm, "_ready_timeout"}, 32'd0, 32'd1);
         return;
      end
      insn_valid = 1'b1; insn_opcode = opc; insn_dst = d; insn_src = s; insn_imm = imm;
      @(posedge clk);
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (n == 1) begin
            insn_valid = 1'b0;
            insn_opcode = 8'h00; insn_dst = 4'd0; insn_src = 4'd0; insn_imm = 32'd0;
         end
         if (rf_re) begin
            if (nrd < 8) rda[nrd] = rf_raddr;
            nrd++;
         end
         if (rf_we)   begin nwe++; wa = rf_waddr; wd = rf_wdata; end
         if (done)    begin ndone++; done_cyc = n; end
         if (illegal) begin nill++; ill_cyc = n; end
         if (rf_re && rf_we) overlap++;
         if (exp_legal) begin
            if (n <= lat && insn_ready) rdy_bad++;
            if (n == lat + 1 && !insn_ready) rdy_bad++;
            if (n == lat - 1) begin exop = alu_op; ea = alu_a; eb = alu_b; end
            if (n == lat) begin ha = alu_a; hb = alu_b; end
         end else if (n == 1 && !insn_ready) rdy_bad++;
      end

      check({nm, "_ready"},   rdy_bad, 0);
      check({nm, "_overlap"}, overlap, 0);
      if (exp_legal) begin
         check({nm, "_done_cyc"}, done_cyc, lat);
         check({nm, "_ndone"},    ndone, 1);
         check({nm, "_nwe"},      nwe, 1);
         check({nm, "_waddr"},    {28'd0, wa}, {28'd0, d});
         check({nm, "_wdata"},    wd, exp_wdata);
         check({nm, "_nill"},     nill, 0);
         check({nm, "_nrd"},      nrd, exp_nrd);
         for (int i = 0; i < exp_nrd && i < 2; i++)
            check($sformatf("%s_raddr%0d", nm, i), {28'd0, rda[i]}, {28'd0, erda[i]});
         check({nm, "_alu_op"}, {28'd0, exop}, {28'd0, opc[7:4]});
         check({nm, "_hold_a"}, ha, ea);
         check({nm, "_hold_b"}, hb, eb);
      end else begin
         check({nm, "_ill_cyc"}, ill_cyc, 1);
         check({nm, "_nill"},    nill, 1);
         check({nm, "_nwe"},     nwe, 0);
         check({nm, "_ndone"},   ndone, 0);
         check({nm, "_nrd"},     nrd, 0);
      end
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [7:0]  opc;
      logic [3:0]  dst;
      logic [3:0]  src;
      logic [31:0] imm;
      logic [31:0] dval;
      logic [31:0] sval;
      logic        legal;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   localparam int NV = 16;
   vec_t tbl [NV];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      logic [7:0]  opc;
      logic [3:0]  d, s;
      logic [31:0] imm, b, exp;
      logic        lg;

      tbl[0]  = '{8'hAC, 4'd1,  4'd2,  32'h0,         32'hF0F0_1234, 32'h0FF0_4321, 1'b1, 32'hFF00_5115, 4};
      tbl[1]  = '{8'h04, 4'd3,  4'd0,  32'hFFFF_FFFF, 32'd5,         32'd0,         1'b1, 32'h0000_0004, 3};
      tbl[2]  = '{8'hB4, 4'd0,  4'd0,  32'h1234_5678, 32'h0,         32'h0,         1'b1, 32'h1234_5678, 2};
      tbl[3]  = '{8'hAC, 4'd10, 4'd2,  32'h0,         32'h0,         32'h1,         1'b0, 32'h0,         0};
      tbl[4]  = '{8'hD4, 4'd1,  4'd0,  32'h0,         32'h0,         32'h0,         1'b0, 32'h0,         0};
      tbl[5]  = '{8'h07, 4'd1,  4'd0,  32'h1,         32'h0,         32'h0,         1'b0, 32'h0,         0};
      tbl[6]  = '{8'h84, 4'd6,  4'd0,  32'h0,         32'd1,         32'h0,         1'b1, 32'hFFFF_FFFF, 3};
      tbl[7]  = '{8'h1C, 4'd7,  4'd7,  32'h0,         32'h1234,      32'h1234,      1'b1, 32'h0,         4};
      tbl[8]  = '{8'hC4, 4'd2,  4'd0,  32'd4,         32'h8000_0000, 32'h0,         1'b1, 32'hF800_0000, 3};
      tbl[9]  = '{8'hBC, 4'd5,  4'd10, 32'h0,         32'h0,         32'hCAFE_0000, 1'b1, 32'hCAFE_0000, 3};
      tbl[10] = '{8'h0C, 4'd1,  4'd11, 32'h0,         32'h0,         32'h0,         1'b0, 32'h0,         0};
      tbl[11] = '{8'hE4, 4'd1,  4'd0,  32'h0,         32'h0,         32'h0,         1'b0, 32'h0,         0};
`ifdef EBPF_DIV0_GUARD_EN
      tbl[12] = '{8'h3C, 4'd4,  4'd5,  32'h0,         32'd100,       32'd0,         1'b1, 32'd0,         4};
      tbl[13] = '{8'h9C, 4'd4,  4'd5,  32'h0,         32'd100,       32'd0,         1'b1, 32'd100,       4};
`else
      tbl[12] = '{8'h3C, 4'd4,  4'd5,  32'h0,         32'd100,       32'd0,         1'b1, 32'hFFFF_FFFF, 4};
      tbl[13] = '{8'h9C, 4'd4,  4'd5,  32'h0,         32'd100,       32'd0,         1'b1, 32'hA5A5_A5A5, 4};
`endif
      tbl[14] = '{8'h2C, 4'd8,  4'd9,  32'h0,         32'h0001_0000, 32'h0001_0001, 1'b1, 32'h0001_0000, 4};
      tbl[15] = '{8'h74, 4'd9,  4'd0,  32'h24,        32'h0000_00F0, 32'h0,         1'b1, 32'h0000_000F, 3};

      rst_n = 1'b0; insn_valid = 1'b0; insn_opcode = 8'h0; insn_dst = 4'd0;
      insn_src = 4'd0; insn_imm = 32'd0; pre_we = 1'b0; pre_addr = 4'd0; pre_data = 32'd0;
      rf_rdata = 32'd0;
      for (int i = 0; i < 16; i++) begin rf_mem[i] = 32'd0; ref_regs[i] = 32'd0; end

      // ---- reset state ----
      repeat (3) @(negedge clk);
      check("rst_ready",   {31'd0, insn_ready}, 32'd0);
      check("rst_re",      {31'd0, rf_re},      32'd0);
      check("rst_we",      {31'd0, rf_we},      32'd0);
      check("rst_done",    {31'd0, done},       32'd0);
      check("rst_illegal", {31'd0, illegal},    32'd0);
      check("rst_raddr",   {28'd0, rf_raddr},   32'd0);
      check("rst_waddr",   {28'd0, rf_waddr},   32'd0);
      check("rst_wdata",   rf_wdata,            32'd0);
      check("rst_alu_a",   alu_a,               32'd0);
      check("rst_alu_b",   alu_b,               32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready_after", {31'd0, insn_ready}, 32'd1);

      for (int i = 0; i < 16; i++) set_reg(4'(i), $urandom);

      // ---- table ----
      for (int i = 0; i < NV; i++) begin
         if (tbl[i].opc[3] && tbl[i].src <= 4'd10) set_reg(tbl[i].src, tbl[i].sval);
         if (tbl[i].dst <= 4'd10) set_reg(tbl[i].dst, tbl[i].dval);
         run_insn($sformatf("tbl%0d", i), tbl[i].opc, tbl[i].dst, tbl[i].src, tbl[i].imm,
                  tbl[i].legal, tbl[i].exp, tbl[i].lat);
         if (tbl[i].legal) ref_regs[tbl[i].dst] = tbl[i].exp;
      end

      // ---- reset during RD_SRC of an XOR ----
      set_reg(4'd1, 32'hF0F0_1234);
      set_reg(4'd2, 32'h0FF0_4321);
      insn_valid = 1'b1; insn_opcode = 8'hAC; insn_dst = 4'd1; insn_src = 4'd2; insn_imm = 32'd0;
      @(posedge clk);
      @(negedge clk);
      insn_valid = 1'b0;
      @(negedge clk);
      check("mrst_in_rd_src", {27'd0, rf_re, rf_raddr}, {27'd0, 1'b1, 4'd2});
      rst_n = 1'b0;
      @(negedge clk);
      check("mrst_we",    {31'd0, rf_we},      32'd0);
      check("mrst_done",  {31'd0, done},       32'd0);
      check("mrst_ready", {31'd0, insn_ready}, 32'd0);
      rst_n = 1'b1;
      begin
         int nwe_after, ndone_after;
         nwe_after = 0; ndone_after = 0;
         for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) check("mrst_ready_release", {31'd0, insn_ready}, 32'd1);
            if (rf_we) nwe_after++;
            if (done)  ndone_after++;
         end
         check("mrst_no_we",   nwe_after, 0);
         check("mrst_no_done", ndone_after, 0);
      end
      check("mrst_r1_kept", rf_mem[1], 32'hF0F0_1234);
      run_insn("mrst_follow", 8'hAC, 4'd1, 4'd2, 32'd0, 1'b1, 32'hFF00_5115, 4);
      ref_regs[1] = 32'hFF00_5115;

      // ---- randomized instructions vs architectural model ----
      for (int i = 0; i < 300; i++) begin
         opc[7:4] = 4'($urandom_range(0, 15));
         opc[3]   = 1'($urandom_range(0, 1));
         opc[2:0] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b100;
         d   = 4'($urandom_range(0, 11));
         s   = 4'($urandom_range(0, 12));
         imm = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         if (opc[3] && s <= 4'd10 && (opc[7:4] == 4'h3 || opc[7:4] == 4'h9)
             && $urandom_range(0, 2) == 0)
            set_reg(s, 32'd0);
         lg  = model_legal(opc, d, s);
         exp = 32'd0;
         if (lg) begin
            b   = opc[3] ? ref_regs[s] : imm;
            exp = model_result(opc[7:4], ref_regs[d], b);
         end
         run_insn($sformatf("rnd%0d", i), opc, d, s, imm, lg, exp, lg ? model_lat(opc) : 0);
         if (lg) ref_regs[d] = exp;
      end

      for (int i = 0; i <= 10; i++)
         check($sformatf("final_r%0d", i), rf_mem[i], ref_regs[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
